// File: rtl/regs7_serializer.sv
// Seven-word parallel-to-serial converter: loads a whole frame, then emits it oldest word first
// with valid/ready handshaking on both sides and zero-bubble back-to-back frames.
//   state | meaning
//   IDLE  | no frame held, ready to load
//   SHIFT | frame held, dout_valid high, beat counter selects position in frame
module regs7_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int REGDEPTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din07,
    input  logic [DATA_WIDTH-1:0] din06,
    input  logic [DATA_WIDTH-1:0] din05,
    input  logic [DATA_WIDTH-1:0] din04,
    input  logic [DATA_WIDTH-1:0] din03,
    input  logic [DATA_WIDTH-1:0] din02,
    input  logic [DATA_WIDTH-1:0] din01,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(REGDEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_buf [REGDEPTH];
    logic                  w_load;
    logic                  w_xfer;

    assign dout_valid = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT);
    assign dout_last  = (r_state == SHIFT) && (r_cnt == LAST_IDX);
    assign in_ready   = (r_state == IDLE) || (dout_last && dout_ready);
    assign dout       = r_buf[0];
    assign w_load     = in_valid && in_ready;
    assign w_xfer     = dout_valid && dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A load can only coincide with a transfer on the last beat, so it simply restarts the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = 3'd0;
        end else if (w_xfer) begin
            if (r_cnt == LAST_IDX) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end else begin
                w_cnt_nxt = r_cnt + 3'd1;
            end
        end
    end

    // Entry 0 is always the word on dout; zeros shift in so dout returns to 0 after a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGDEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_load) begin
            r_buf[0] <= din07;
            r_buf[1] <= din06;
            r_buf[2] <= din05;
            r_buf[3] <= din04;
            r_buf[4] <= din03;
            r_buf[5] <= din02;
            r_buf[6] <= din01;
        end else if (w_xfer) begin
            for (int i = 0; i < REGDEPTH - 1; i++) begin
                r_buf[i] <= r_buf[i+1];
            end
            r_buf[REGDEPTH-1] <= '0;
        end
    end

endmodule

// File: tb/tb_regs7_serializer.sv
// Scoreboard bench for regs7_serializer: each accepted frame queues its seven words; a monitor
// checks every output cycle against the queue (handshake flags derived from how many words remain).
module tb_regs7_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] din07, din06, din05, din04, din03, din02, din01;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    regs7_serializer #(.DATA_WIDTH(8), .REGDEPTH(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din07      (din07),
        .din06      (din06),
        .din05      (din05),
        .din04      (din04),
        .din03      (din03),
        .din02      (din02),
        .din01      (din01),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, decide acceptance just before posedge, enqueue after posedge.
    task automatic step(input logic v, input logic [55:0] f, input logic rdy);
        logic ld;
        @(negedge clk);
        in_valid   = v;
        dout_ready = rdy;
        {din07, din06, din05, din04, din03, din02, din01} = f;
        #4;
        ld = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (ld) begin
            for (int k = 0; k < 7; k++) begin
                exp_q.push_back(f[55 - 8*k -: 8]);
            end
        end
    endtask

    // Monitor: sampled 1 time unit before each rising edge, when all inputs are settled.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            chk("dout_valid", {31'd0, dout_valid}, {31'd0, exp_q.size() != 0});
            chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
            chk("dout_last", {31'd0, dout_last}, {31'd0, exp_q.size() == 1});
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && dout_ready)});
            if (exp_q.size() != 0) begin
                chk("dout", {24'd0, dout}, {24'd0, exp_q[0]});
                if (dout_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] fa;
        logic [55:0] fb;
        logic [55:0] fr;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        dout_ready = 1'b0;
        {din07, din06, din05, din04, din03, din02, din01} = '0;
        #3;
        chk("rst dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst dout", {24'd0, dout}, 32'd0);
        chk("rst dout_last", {31'd0, dout_last}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst in_ready", {31'd0, in_ready}, 32'd1);

        // single frame
        step(1'b1, 56'h07060504030201, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // back-to-back frames with in_valid held
        fa = 56'h17161514131211;
        fb = 56'h27262524232221;
        step(1'b1, fa, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, fb, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // backpressure while dout = 0x05
        step(1'b1, 56'h07060504030201, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);
        repeat (6) step(1'b0, '0, 1'b1);

        // load attempt during beat 3 is ignored
        step(1'b1, 56'h47464544434241, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b1, {7{8'hAA}}, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // asynchronous reset mid-frame, after beat 0x04
        step(1'b1, 56'h07060504030201, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("midrst dout", {24'd0, dout}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 56'h37363534333231, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // last-beat stall with a new frame pending
        step(1'b1, 56'h57565554535251, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        repeat (2) step(1'b1, 56'h67666564636261, 1'b0);
        step(1'b1, 56'h67666564636261, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            fr = {$urandom(), $urandom()};
            step($urandom_range(0, 2) != 0, fr, $urandom_range(0, 3) != 0);
        end

        // drain, bounded
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1);
        chk("drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regs7_serializer.md
REGS7_SERIALIZER -- requirements
Module: regs7_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of each word.
REQ-002 SHALL have parameter REGDEPTH, default 7, the number of words per frame; only the value 7 is supported.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have ports din07..din01, input, DATA_WIDTH each, one parallel frame; din07 is the oldest word, din01 the newest.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning a frame is present on din07..din01.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block can load a frame this cycle.
REQ-008 SHALL have port dout, output, DATA_WIDTH, the current serial word.
REQ-009 SHALL have port dout_valid, output, 1 bit, meaning dout holds a valid beat.
REQ-010 SHALL have port dout_ready, input, 1 bit, meaning the downstream accepts the beat.
REQ-011 SHALL have port dout_last, output, 1 bit, meaning the current beat is the final word (din01) of the frame.
REQ-012 SHALL have port busy, output, 1 bit, meaning a frame is in progress.

Function
REQ-013 SHALL implement two states: IDLE (no frame held) and SHIFT (frame being emitted).
REQ-014 SHALL define a frame load as in_valid && in_ready at a rising clk edge.
REQ-015 SHALL define a beat transfer as dout_valid && dout_ready at a rising clk edge.
REQ-016 SHALL, on a load, capture all seven words into an internal 7-entry buffer and go to SHIFT with beat counter = 0.
REQ-017 SHALL emit words oldest first: din07, din06, ..., din01, so that a downstream 7-deep shift line fed by dout reconstructs the frame taps in order.
REQ-018 SHALL drive dout from registers only, never combinationally from din*; the first beat appears the cycle after the load.
REQ-019 SHALL assert dout_valid exactly while in SHIFT.
REQ-020 SHALL, on each transfer, advance the buffer by one word and increment the 3-bit beat counter.
REQ-021 SHALL, when dout_valid && !dout_ready, hold dout, dout_last, the counter and the buffer unchanged (stall), for any number of cycles.
REQ-022 SHALL assert dout_last iff in SHIFT and counter == 6.
REQ-023 SHALL drive in_ready = IDLE || (dout_last && dout_ready), combinationally.
REQ-024 SHALL, on a transfer with dout_last and no simultaneous load, return to IDLE.
REQ-025 SHALL, on a transfer with dout_last and a simultaneous load, stay in SHIFT with counter = 0 and the new frame loaded, giving zero bubble cycles between frames.
REQ-026 SHALL ignore in_valid and din* whenever in_ready is low; the held frame is never overwritten mid-frame.
REQ-027 SHALL sustain a throughput of one word per cycle with dout_ready held high, i.e. 7 cycles per frame.
REQ-028 SHALL drive busy = 1 iff in SHIFT.
REQ-029 SHALL never wrap the counter past 6; counter values 7 are unreachable.

Reset
REQ-030 SHALL, while rst_n = 0, force state IDLE, counter 0, buffer all zeros, dout 0, dout_valid 0, dout_last 0, busy 0, with in_ready = 1 once rst_n is released.
REQ-031 SHALL, on rst_n assertion mid-frame, abort the frame immediately and discard all remaining beats.
REQ-032 SHALL not begin operation before the first rising clk edge after rst_n deassertion.

Verification
REQ-033 Single frame: din07..din01 = 0x07..0x01, one-cycle in_valid, dout_ready = 1 -> dout = 07,06,05,04,03,02,01 on 7 consecutive cycles starting the cycle after load; dout_last only on 0x01; IDLE afterwards.
REQ-034 Back-to-back frames: frame A = 0x17..0x11, then frame B = 0x27..0x21 offered with in_valid held high -> 14 contiguous valid beats 17..11,27..21; in_ready high only in the cycle of beat 0x11.
REQ-035 Backpressure: dout_ready low for 3 cycles while dout = 0x05 -> dout stays 0x05 and the counter is frozen; the sequence resumes with 0x04 with no loss or duplication.
REQ-036 Load ignored: in_valid pulsed with 0xAA on all inputs during beat 3 of a frame -> in_ready = 0 and the output stream is unaffected.
REQ-037 Reset mid-frame: rst_n pulsed low asynchronously (between edges) after beat 0x04 -> dout_valid = 0 and dout = 0 immediately; the next frame starts at its din07.
REQ-038 Last-beat stall: dout_last with dout_ready = 0 and a new frame pending -> in_ready = 0 and no load until dout_ready = 1.
